// File: rtl/ram_interface_pkg.sv
// ram_interface_pkg
// Shared cache-side constants for the RAM interface block: default bus
// widths, the FSM state encoding and a helper that sizes the timeout counter.
// No ports (package).
package ram_interface_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Counter only ever has to reach timeout-1, so $clog2(timeout) bits suffice.
  // Clamp to 1 so a degenerate timeout still yields a legal vector width.
  function automatic int counterWidth(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ram_interface_if.sv
// ram_interface_if
// Bundles the cache-side request/response handshake and the RAM-side access
// strobe into one interface.
//   Cache side : req_valid, req_we, req_addr, req_wdata -> block
//                req_ready, resp_valid, resp_data, resp_err <- block
//   RAM side   : ram_req, ram_we, ram_addr, ram_wdata <- block
//                ram_ack, ram_rdata -> block
// Modports: slave = the ram_interface block, master = its environment.
interface ram_interface_if
  import ram_interface_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [WIDTH-1:0]      req_wdata;
  logic                  req_ready;
  logic                  resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic                  resp_err;

  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_wdata;
  logic                  ram_ack;
  logic [WIDTH-1:0]      ram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_ack, ram_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_ack, ram_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_interface_counter.sv
// component_timeout_counter
// Counts cycles spent waiting on the RAM and flags when the last allowed
// cycle (TIMEOUT-1) is reached.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear to 0 (takes priority over enable)
//   i_enable       : advance by one this cycle
//   o_expired      : count == TIMEOUT-1
module component_timeout_counter
  import ram_interface_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = counterWidth(TIMEOUT)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Enable is never asserted once expired, so the count cannot wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/ram_interface.sv
// ram_interface
// Sits between the cache and a RAM with a request/ack handshake. Takes one
// read or write-through request at a time, holds ram_req with constant
// address/data until the RAM acks or TIMEOUT cycles pass, then returns a
// one-cycle response (read data, or zero for writes and timeouts).
//   i_clk   : clock, all state on rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : ram_interface_if.slave (cache request/response + RAM access)
module ram_interface
  import ram_interface_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ram_interface_if.slave io_bus
);

  localparam int CNT_W = counterWidth(TIMEOUT);

  state_t                r_state;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH-1:0]      r_respData;
  logic                  r_respErr;

  logic w_accept;
  logic w_ack;
  logic w_expired;
  logic w_cntEnable;

  assign w_accept    = (r_state == ST_IDLE) && io_bus.req_valid;
  // Acks seen outside ACCESS are deliberately dropped here.
  assign w_ack       = (r_state == ST_ACCESS) && io_bus.ram_ack;
  assign w_cntEnable = (r_state == ST_ACCESS) && !io_bus.ram_ack && !w_expired;

  component_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_accept),
    .i_enable  (w_cntEnable),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (io_bus.req_valid) r_state <= ST_ACCESS;
        ST_ACCESS: if (io_bus.ram_ack || w_expired) r_state <= ST_RESP;
        ST_RESP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Request fields are captured once at accept so the RAM sees them stable
  // for the whole access, whatever the cache does with its inputs meanwhile.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= io_bus.req_we;
      r_addr  <= io_bus.req_addr;
      r_wdata <= io_bus.req_wdata;
    end
  end

  // Ack is tested first so an ack on the final allowed cycle is a success.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_respData <= '0;
      r_respErr  <= 1'b0;
    end else if (w_ack) begin
      r_respData <= r_we ? '0 : io_bus.ram_rdata;
      r_respErr  <= 1'b0;
    end else if ((r_state == ST_ACCESS) && w_expired) begin
      r_respData <= '0;
      r_respErr  <= 1'b1;
    end
  end

  assign io_bus.req_ready  = (r_state == ST_IDLE);
  assign io_bus.resp_valid = (r_state == ST_RESP);
  assign io_bus.resp_data  = r_respData;
  assign io_bus.resp_err   = r_respErr;
  assign io_bus.ram_req    = (r_state == ST_ACCESS);
  assign io_bus.ram_we     = r_we;
  assign io_bus.ram_addr   = r_addr;
  assign io_bus.ram_wdata  = r_wdata;

endmodule

// File: tb/tb_ram_interface.sv
// tb_ram_interface
// Self-checking bench for ram_interface. The bench plays the RAM (a memory
// array) and predicts every cycle from transaction-level timing: a request
// accepted in cycle c with the RAM acking after d ACCESS cycles completes in
// cycle c+d+2, or times out with its response in cycle c+TIMEOUT+1.
module tb_ram_interface;
  import ram_interface_pkg::*;

  localparam int WIDTH      = DEFAULT_WIDTH;
  localparam int ADDR_WIDTH = DEFAULT_ADDR_WIDTH;
  localparam int TIMEOUT    = 16;
  localparam int NEVER      = TIMEOUT + 4;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  ram_interface_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  ram_interface #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .io_bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]      mem [1<<ADDR_WIDTH];
  bit                    mBusy;
  int                    mAckCyc;
  int                    mRespCyc;
  logic                  mWe;
  logic [ADDR_WIDTH-1:0] mAddr;
  logic [WIDTH-1:0]      mWdata;
  logic [WIDTH-1:0]      mExpData;
  logic                  mExpErr;
  logic [WIDTH-1:0]      mLastData;
  logic                  mLastErr;
  int                    expResps;
  int                    dutResps;
  int                    dutAccepts[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               tag, cyc, actual, expected);
    end
  endtask

  task automatic randomizeReqFields();
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = ADDR_WIDTH'($urandom);
    bus.req_wdata = WIDTH'($urandom);
  endtask

  // Advance one clock, compare the new cycle against the model, then drive
  // the RAM side for that cycle.
  task automatic stepCycle();
    if (bus.req_valid && bus.req_ready) dutAccepts.push_back(cyc);
    @(posedge clk);
    cyc++;
    #1;
    if (bus.resp_valid === 1'b1) dutResps++;
    if (mBusy && cyc > mRespCyc) mBusy = 1'b0;
    if (mBusy && cyc == mRespCyc) begin
      checkOutput("respValid", bus.resp_valid, 1);
      checkOutput("respData", bus.resp_data, mExpData);
      checkOutput("respErr", bus.resp_err, mExpErr);
      checkOutput("ramReqInResp", bus.ram_req, 0);
      checkOutput("readyInResp", bus.req_ready, 0);
      mLastData = mExpData;
      mLastErr  = mExpErr;
    end else if (mBusy) begin
      checkOutput("ramReq", bus.ram_req, 1);
      checkOutput("readyInAccess", bus.req_ready, 0);
      checkOutput("respValidInAccess", bus.resp_valid, 0);
      checkOutput("ramWe", bus.ram_we, mWe);
      checkOutput("ramAddr", bus.ram_addr, mAddr);
      checkOutput("ramWdata", bus.ram_wdata, mWdata);
      checkOutput("respDataHold", bus.resp_data, mLastData);
      checkOutput("respErrHold", bus.resp_err, mLastErr);
    end else begin
      checkOutput("readyIdle", bus.req_ready, 1);
      checkOutput("ramReqIdle", bus.ram_req, 0);
      checkOutput("respValidIdle", bus.resp_valid, 0);
      checkOutput("respDataHold", bus.resp_data, mLastData);
      checkOutput("respErrHold", bus.resp_err, mLastErr);
    end
    if (mBusy && cyc < mRespCyc) begin
      bus.ram_ack   = (cyc == mAckCyc);
      bus.ram_rdata = (cyc == mAckCyc && !mWe) ? mem[mAddr] : WIDTH'($urandom);
    end else begin
      bus.ram_ack   = 1'($urandom_range(0, 1));
      bus.ram_rdata = WIDTH'($urandom);
    end
  endtask

  // Issue one request after `gap` idle cycles. delay = ACCESS cycles before
  // the RAM acks (0 = ack in the first ACCESS cycle); delay >= TIMEOUT means
  // the RAM never acks. hold keeps req_valid high after the accept.
  task automatic applyStimulus(input logic we, input logic [ADDR_WIDTH-1:0] addr,
                               input logic [WIDTH-1:0] wdata, input int delay,
                               input int gap, input bit hold);
    while (mBusy) stepCycle();
    if (gap > 0) begin
      bus.req_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        randomizeReqFields();
        stepCycle();
      end
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    mBusy  = 1'b1;
    mWe    = we;
    mAddr  = addr;
    mWdata = wdata;
    if (delay < TIMEOUT) begin
      mAckCyc  = cyc + 1 + delay;
      mRespCyc = cyc + 2 + delay;
      mExpErr  = 1'b0;
      if (we) begin
        mExpData  = '0;
        mem[addr] = wdata;
      end else begin
        mExpData = mem[addr];
      end
    end else begin
      mAckCyc  = -1;
      mRespCyc = cyc + TIMEOUT + 1;
      mExpData = '0;
      mExpErr  = 1'b1;
    end
    expResps++;
    stepCycle();
    randomizeReqFields();
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    while (mBusy) stepCycle();
    stepCycle();
  endtask

  // Reset pulsed two cycles into an access that would otherwise time out.
  task automatic resetMidAccess();
    applyStimulus(1'b0, 8'h21, 8'h00, NEVER, 1, 1'b0);
    stepCycle();
    #2 rstN = 1'b0;
    #1;
    checkOutput("rstRamReqAsync", bus.ram_req, 0);
    checkOutput("rstReadyAsync", bus.req_ready, 1);
    checkOutput("rstRespValid", bus.resp_valid, 0);
    mBusy     = 1'b0;
    mAckCyc   = -1;
    mLastData = '0;
    mLastErr  = 1'b0;
    expResps--;
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      checkOutput("rstHoldRamReq", bus.ram_req, 0);
      checkOutput("rstHoldRespValid", bus.resp_valid, 0);
    end
    #2 rstN = 1'b1;
    repeat (TIMEOUT + 4) stepCycle();
  endtask

  initial begin
    int prevAccept;
    int r;
    int delay;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = WIDTH'($urandom);
    mBusy     = 1'b0;
    mAckCyc   = -1;
    mRespCyc  = 0;
    mWe       = 1'b0;
    mAddr     = '0;
    mWdata    = '0;
    mExpData  = '0;
    mExpErr   = 1'b0;
    mLastData = '0;
    mLastErr  = 1'b0;
    expResps  = 0;
    dutResps  = 0;

    #1;
    checkOutput("resetReady", bus.req_ready, 1);
    checkOutput("resetRamReq", bus.ram_req, 0);
    checkOutput("resetRespValid", bus.resp_valid, 0);
    checkOutput("resetRespData", bus.resp_data, 0);
    checkOutput("resetRespErr", bus.resp_err, 0);
    checkOutput("resetRamWe", bus.ram_we, 0);
    checkOutput("resetRamAddr", bus.ram_addr, 0);
    checkOutput("resetRamWdata", bus.ram_wdata, 0);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] read with ack after 3 cycles");
    mem[8'h40] = 8'hA5;
    applyStimulus(1'b0, 8'h40, 8'h00, 3, 1, 1'b0);
    drain();
    $display("[TB] write with ack in the first access cycle");
    applyStimulus(1'b1, 8'h12, 8'h3C, 0, 1, 1'b0);
    drain();
    applyStimulus(1'b0, 8'h12, 8'h00, 2, 0, 1'b0);
    drain();
    $display("[TB] read that times out");
    applyStimulus(1'b0, 8'h55, 8'h00, NEVER, 1, 1'b0);
    drain();
    $display("[TB] ack on the last allowed cycle");
    mem[8'h66] = 8'h7E;
    applyStimulus(1'b0, 8'h66, 8'h00, TIMEOUT - 1, 1, 1'b0);
    drain();
    $display("[TB] reset in the middle of an access");
    resetMidAccess();

    $display("[TB] req_valid held high, immediate acks");
    dutAccepts.delete();
    for (int i = 0; i < 6; i++)
      applyStimulus(1'($urandom_range(0, 1)), ADDR_WIDTH'($urandom),
                    WIDTH'($urandom), 0, 0, 1'b1);
    drain();
    checkOutput("continuousAcceptCount", dutAccepts.size(), 6);
    prevAccept = -1;
    foreach (dutAccepts[i]) begin
      if (prevAccept >= 0)
        checkOutput("acceptSpacing", dutAccepts[i] - prevAccept, 3);
      prevAccept = dutAccepts[i];
    end

    $display("[TB] random traffic");
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      delay = $urandom_range(0, 4);
      else if (r < 8) delay = $urandom_range(5, TIMEOUT - 1);
      else            delay = NEVER;
      applyStimulus(1'($urandom_range(0, 1)), ADDR_WIDTH'($urandom_range(0, 15)),
                    WIDTH'($urandom), delay, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end
    drain();
    checkOutput("responseCount", dutResps, expResps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time %0t, expected finish before 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
